busmux_arb: RTL and testbench



---
 rtl/busmux_arb.sv | 83 ++++++++
 tb/tb_busmux_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/busmux_arb.sv
// Registered N-way bus source multiplexer with fixed-priority or round-robin
// arbitration, grant lock for multi-cycle transfers and downstream stall.
module busmux_arb #(
    parameter int WIDTH  = 8,
    parameter int NSRC   = 4,
    parameter int RRMODE = 1,
    parameter int SELW   = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSRC*WIDTH-1:0] inData,
    input  logic [NSRC-1:0]       inReq,
    input  logic                  inLock,
    input  logic                  inStall,
    output logic [WIDTH-1:0]      outData,
    output logic                  outValid,
    output logic [NSRC-1:0]       outGrant,
    output logic [SELW-1:0]       outSel
);

    logic [WIDTH-1:0] srcWord [NSRC];
    logic [SELW-1:0]  last;
    logic [SELW-1:0]  win;
    logic [SELW-1:0]  cand;
    logic [31:0]      lastExt;
    logic             found;

    for (genvar i = 0; i < NSRC; i++) begin : gSrc
        assign srcWord[i] = inData[i*WIDTH +: WIDTH];
    end

    assign lastExt = 32'(last);

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        if (inLock && outValid && inReq[outSel]) begin
            found = 1'b1;
            win   = outSel;
        end else if (RRMODE != 0) begin
            // Search starts one past the last winner and wraps modulo NSRC.
            for (int unsigned k = 1; k <= NSRC; k++) begin
                cand = SELW'((lastExt + k) % NSRC);
                if (!found && inReq[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end else begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                cand = SELW'(i);
                if (!found && inReq[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outData  <= '0;
            outValid <= 1'b0;
            outGrant <= '0;
            outSel   <= '0;
            last     <= SELW'(NSRC - 1);
        end else if (!inStall) begin
            if (found) begin
                outData  <= srcWord[win];
                outValid <= 1'b1;
                outGrant <= NSRC'(1) << win;
                outSel   <= win;
                last     <= win;
            end else begin
                // Idle: data, select and pointer keep their last values.
                outValid <= 1'b0;
                outGrant <= '0;
            end
        end
    end

endmodule

// File: tb/tb_busmux_arb.sv
// Directed bench for busmux_arb: round-robin and fixed-priority 4x8 builds
// plus a 3x16 round-robin build, each checked against hand-computed values.
module tb_busmux_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inData;
    logic [3:0]  inReq;
    logic        inLock;
    logic        inStall;

    logic [7:0]  rrData, fpData;
    logic        rrValid, fpValid;
    logic [3:0]  rrGrant, fpGrant;
    logic [1:0]  rrSel, fpSel;

    logic [47:0] d3In;
    logic [2:0]  d3Req;
    logic        d3Lock, d3Stall;
    logic [15:0] d3Data;
    logic        d3Valid;
    logic [2:0]  d3Grant;
    logic [1:0]  d3Sel;

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    busmux_arb #(.WIDTH(8), .NSRC(4), .RRMODE(1)) dutRr (
        .clk(clk), .rst(rst), .inData(inData), .inReq(inReq), .inLock(inLock),
        .inStall(inStall), .outData(rrData), .outValid(rrValid),
        .outGrant(rrGrant), .outSel(rrSel)
    );

    busmux_arb #(.WIDTH(8), .NSRC(4), .RRMODE(0)) dutFp (
        .clk(clk), .rst(rst), .inData(inData), .inReq(inReq), .inLock(inLock),
        .inStall(inStall), .outData(fpData), .outValid(fpValid),
        .outGrant(fpGrant), .outSel(fpSel)
    );

    busmux_arb #(.WIDTH(16), .NSRC(3), .RRMODE(1)) dut3 (
        .clk(clk), .rst(rst), .inData(d3In), .inReq(d3Req), .inLock(d3Lock),
        .inStall(d3Stall), .outData(d3Data), .outValid(d3Valid),
        .outGrant(d3Grant), .outSel(d3Sel)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        inData  = 32'hDEADBEEF;
        inReq   = 4'b1111;
        inLock  = 1'b1;
        inStall = 1'b1;
        doReset();
        obs = {rrValid, rrGrant, rrSel, rrData};
        nVec++;
        if (obs !== 15'h0) begin
            nErr++;
            $display("FAIL reset_rr: got %h want %h", obs, 15'h0);
        end
        obs = {fpValid, fpGrant, fpSel, fpData};
        nVec++;
        if (obs !== 15'h0) begin
            nErr++;
            $display("FAIL reset_fp: got %h want %h", obs, 15'h0);
        end
        inLock  = 1'b0;
        inStall = 1'b0;
        inReq   = 4'b0100;
        inData  = {8'h00, 8'h5A, 8'h00, 8'h00};
        tick();
        obs = {rrValid, rrGrant, rrSel, rrData};
        nVec++;
        if (obs !== {1'b1, 4'b0100, 2'd2, 8'h5A}) begin
            nErr++;
            $display("FAIL reset_first_grant: got %h want %h", obs, {1'b1, 4'b0100, 2'd2, 8'h5A});
        end
    endtask

    task automatic test_fixed_priority();
        logic [14:0] obs;
        doReset();
        inData = {8'h33, 8'h22, 8'h11, 8'h00};
        inReq  = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {fpValid, fpGrant, fpSel, fpData};
            nVec++;
            if (obs !== {1'b1, 4'b0010, 2'd1, 8'h11}) begin
                nErr++;
                $display("FAIL fixed_prio_src1[%0d]: got %h want %h", i, obs, {1'b1, 4'b0010, 2'd1, 8'h11});
            end
        end
        inReq = 4'b1000;
        tick();
        obs = {fpValid, fpGrant, fpSel, fpData};
        nVec++;
        if (obs !== {1'b1, 4'b1000, 2'd3, 8'h33}) begin
            nErr++;
            $display("FAIL fixed_prio_src3: got %h want %h", obs, {1'b1, 4'b1000, 2'd3, 8'h33});
        end
    endtask

    task automatic test_round_robin();
        logic [14:0] obs, exp;
        int unsigned seqA [6] = '{0, 1, 2, 3, 0, 1};
        int unsigned seqB [3] = '{3, 0, 3};
        doReset();
        inData = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        inReq  = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = {1'b1, 4'b0001 << seqA[i], 2'(seqA[i]), 8'hA0 + 8'(seqA[i])};
            obs = {rrValid, rrGrant, rrSel, rrData};
            nVec++;
            if (obs !== exp) begin
                nErr++;
                $display("FAIL rr_all[%0d]: got %h want %h", i, obs, exp);
            end
        end
        inReq = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {1'b1, 4'b0001 << seqB[i], 2'(seqB[i]), 8'hA0 + 8'(seqB[i])};
            obs = {rrValid, rrGrant, rrSel, rrData};
            nVec++;
            if (obs !== exp) begin
                nErr++;
                $display("FAIL rr_1001[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_lock();
        logic [14:0] obs, exp;
        logic [7:0]  words [3] = '{8'h11, 8'h22, 8'h33};
        doReset();
        inData = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        inReq  = 4'b1111;
        tick();
        tick();
        obs = {rrValid, rrGrant, rrSel, rrData};
        nVec++;
        if (obs !== {1'b1, 4'b0010, 2'd1, 8'hC1}) begin
            nErr++;
            $display("FAIL lock_pre: got %h want %h", obs, {1'b1, 4'b0010, 2'd1, 8'hC1});
        end
        inLock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inData[15:8] = words[i];
            tick();
            exp = {1'b1, 4'b0010, 2'd1, words[i]};
            obs = {rrValid, rrGrant, rrSel, rrData};
            nVec++;
            if (obs !== exp) begin
                nErr++;
                $display("FAIL lock_hold[%0d]: got %h want %h", i, obs, exp);
            end
        end
        inReq = 4'b1101;
        tick();
        obs = {rrValid, rrGrant, rrSel, rrData};
        nVec++;
        if (obs !== {1'b1, 4'b0100, 2'd2, 8'hC2}) begin
            nErr++;
            $display("FAIL lock_release: got %h want %h", obs, {1'b1, 4'b0100, 2'd2, 8'hC2});
        end
        inLock = 1'b0;
    endtask

    task automatic test_stall_idle();
        logic [14:0] obs;
        doReset();
        inData = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        inReq  = 4'b1111;
        tick();
        tick();
        inStall = 1'b1;
        inData  = 32'h5555_5555;
        for (int i = 0; i < 2; i++) begin
            tick();
            obs = {rrValid, rrGrant, rrSel, rrData};
            nVec++;
            if (obs !== {1'b1, 4'b0010, 2'd1, 8'hB1}) begin
                nErr++;
                $display("FAIL stall_frozen[%0d]: got %h want %h", i, obs, {1'b1, 4'b0010, 2'd1, 8'hB1});
            end
        end
        inStall = 1'b0;
        inData  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        tick();
        obs = {rrValid, rrGrant, rrSel, rrData};
        nVec++;
        if (obs !== {1'b1, 4'b0100, 2'd2, 8'hB2}) begin
            nErr++;
            $display("FAIL stall_resume2: got %h want %h", obs, {1'b1, 4'b0100, 2'd2, 8'hB2});
        end
        tick();
        obs = {rrValid, rrGrant, rrSel, rrData};
        nVec++;
        if (obs !== {1'b1, 4'b1000, 2'd3, 8'hB3}) begin
            nErr++;
            $display("FAIL stall_resume3: got %h want %h", obs, {1'b1, 4'b1000, 2'd3, 8'hB3});
        end
        inReq = 4'b0000;
        tick();
        obs = {rrValid, rrGrant, rrSel, rrData};
        nVec++;
        if (obs !== {1'b0, 4'b0000, 2'd3, 8'hB3}) begin
            nErr++;
            $display("FAIL idle_hold: got %h want %h", obs, {1'b0, 4'b0000, 2'd3, 8'hB3});
        end
        inReq = 4'b1111;
        tick();
        obs = {rrValid, rrGrant, rrSel, rrData};
        nVec++;
        if (obs !== {1'b1, 4'b0001, 2'd0, 8'hB0}) begin
            nErr++;
            $display("FAIL idle_wrap: got %h want %h", obs, {1'b1, 4'b0001, 2'd0, 8'hB0});
        end
        tick();
        doReset();
        tick();
        obs = {rrValid, rrGrant, rrSel, rrData};
        nVec++;
        if (obs !== {1'b1, 4'b0001, 2'd0, 8'hB0}) begin
            nErr++;
            $display("FAIL mid_reset_src0: got %h want %h", obs, {1'b1, 4'b0001, 2'd0, 8'hB0});
        end
    endtask

    task automatic test_nsrc3();
        logic [21:0] obs, exp;
        logic [15:0] words [3] = '{16'hBEEF, 16'h1234, 16'hCAFE};
        int unsigned seq [5] = '{0, 1, 2, 0, 1};
        doReset();
        d3In  = {16'hCAFE, 16'h1234, 16'hBEEF};
        d3Req = 3'b111;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = {1'b1, 3'b001 << seq[i], 2'(seq[i]), words[seq[i]]};
            obs = {d3Valid, d3Grant, d3Sel, d3Data};
            nVec++;
            if (obs !== exp || d3Sel === 2'd3) begin
                nErr++;
                $display("FAIL nsrc3_rr[%0d]: got %h want %h", i, obs, exp);
            end
        end
        d3Req = 3'b000;
    endtask

    initial begin
        rst     = 1'b1;
        inData  = '0;
        inReq   = '0;
        inLock  = 1'b0;
        inStall = 1'b0;
        d3In    = '0;
        d3Req   = '0;
        d3Lock  = 1'b0;
        d3Stall = 1'b0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_lock();
        test_stall_idle();
        test_nsrc3();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
